rice_symbol_decoder: RTL and testbench

- Pulls 32-bit MSB-first packed telemetry words into a 64-bit circular bit buffer.
- Aligns the unread bits to the MSB by rotating the buffer left by the read pointer (64-bit rotate-left stage).
- Decodes Rice codewords (unary quotient of q zeros terminated by a '1', then a k-bit remainder) into sample values q*2^k + r.
- Sits between the packet/word source and the sample post-processing (inverse mapping) stage.

---
 rtl/rice_symbol_decoder_if.sv | 24 ++
 rtl/rice_symbol_decoder.sv | 164 ++++++++++++++++
 tb/tb_rice_symbol_decoder.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/rice_symbol_decoder_if.sv
// Handshake bundle for the Rice symbol decoder: packed word input side,
// decoded symbol output side, the Rice parameter and the sticky error flag.
interface rice_symbol_decoder_if #(
  parameter int OUT_W = 24
);
  logic [3:0]       k;
  logic [31:0]      in_data;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] sym_data;
  logic             sym_valid;
  logic             sym_ready;
  logic             err;

  modport master (
    output k, in_data, in_valid, sym_ready,
    input  in_ready, sym_data, sym_valid, err
  );

  modport slave (
    input  k, in_data, in_valid, sym_ready,
    output in_ready, sym_data, sym_valid, err
  );
endinterface

// File: rtl/rice_symbol_decoder.sv
// Rice symbol decoder: packs 32-bit MSB-first words into a 64-bit circular
// bit buffer, aligns unread bits to the MSB with a rotate, and decodes
// unary-quotient / k-bit-remainder codewords into q*2^k + r.
module rice_symbol_decoder #(
  parameter int OUT_W = 24,
  parameter int Q_MAX = 48
) (
  input logic                  clk,
  input logic                  rst,
  rice_symbol_decoder_if.slave bus
);

  typedef enum logic [1:0] {S_UNARY, S_REM, S_OUT, S_ERR} state_t;

  localparam logic [8:0] QMAX9 = 9'(Q_MAX);

  state_t           state, state_nxt;
  logic [63:0]      bit_buf;
  logic [5:0]       rd_ptr;
  logic [5:0]       wr_ptr;
  logic [6:0]       fill, fill_nxt;
  logic [7:0]       q_acc, q_acc_nxt;
  logic [8:0]       q_sum;
  logic [3:0]       k_lat;
  logic             accept;
  logic [63:0]      window;
  logic [6:0]       lz_raw;
  logic             term_seen;
  logic [6:0]       consumed;
  logic [14:0]      rem_p0;
  logic             load_sym;
  logic             set_err;
  logic             sym_done;
  logic [OUT_W-1:0] sym_data_p1;
  logic             vld_p1;
  logic             err_q;
  logic [63:0]      wr_mask;
  logic [63:0]      wr_bits;

  // Leading-zero count of the aligned window; 64 when the window is all zero.
  function automatic logic [6:0] clz64(input logic [63:0] v);
    logic [6:0] n;
    logic       found;
    n     = 7'd64;
    found = 1'b0;
    for (int i = 63; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 7'(63 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Top kk bits of the window, right-justified; kk = 0 yields zero.
  function automatic logic [14:0] rem_bits(input logic [14:0] top, input logic [3:0] kk);
    return top >> (5'd15 - {1'b0, kk});
  endfunction

  // Assemble q*2^k + r and keep only the OUT_W LSBs.
  function automatic logic [OUT_W-1:0] pack_sym(input logic [7:0] q, input logic [3:0] kk,
                                                input logic [14:0] r);
    return OUT_W'(({56'd0, q} << kk) | {49'd0, r});
  endfunction

  // Words always land on a 32-bit half because fill only grows in word steps
  // and the read side consumes whatever it needs from the circular buffer.
  assign wr_ptr       = rd_ptr + fill[5:0];
  assign bus.in_ready = (fill <= 7'd32) && (state != S_ERR);
  assign accept       = bus.in_valid && bus.in_ready;
  assign wr_mask      = {32'hFFFF_FFFF, 32'd0} >> wr_ptr;
  assign wr_bits      = {bus.in_data, 32'd0} >> wr_ptr;

  // Rotate left by rd_ptr so the next unread bit sits at window[63].
  assign window    = (bit_buf << rd_ptr) | (bit_buf >> (7'd64 - {1'b0, rd_ptr}));
  assign lz_raw    = clz64(window);
  assign term_seen = lz_raw < fill;
  assign rem_p0    = rem_bits(window[63:49], k_lat);
  assign sym_done  = (state == S_OUT) && bus.sym_ready;

  assign bus.sym_data  = sym_data_p1;
  assign bus.sym_valid = vld_p1;
  assign bus.err       = err_q;

  // Next-state, bit consumption and quotient accumulation.
  always_comb begin
    state_nxt = state;
    consumed  = 7'd0;
    q_acc_nxt = q_acc;
    q_sum     = 9'd0;
    load_sym  = 1'b0;
    set_err   = 1'b0;
    case (state)
      S_UNARY: begin
        if (fill != 7'd0) begin
          q_sum = {1'b0, q_acc} + {2'b00, (term_seen ? lz_raw : fill)};
          if (q_sum > QMAX9) begin
            state_nxt = S_ERR;
            set_err   = 1'b1;
          end else begin
            q_acc_nxt = q_sum[7:0];
            if (term_seen) begin
              consumed  = lz_raw + 7'd1;
              state_nxt = S_REM;
            end else begin
              consumed = fill;
            end
          end
        end
      end
      S_REM: begin
        if (fill >= {3'b000, k_lat}) begin
          consumed  = {3'b000, k_lat};
          load_sym  = 1'b1;
          state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.sym_ready) state_nxt = S_UNARY;
      end
      default: begin
        state_nxt = S_ERR;
      end
    endcase
    fill_nxt = fill - consumed + (accept ? 7'd32 : 7'd0);
  end

  // Control state: FSM, pointers, quotient, latched k, output stage and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_UNARY;
      rd_ptr      <= 6'd0;
      fill        <= 7'd0;
      q_acc       <= 8'd0;
      k_lat       <= bus.k;
      vld_p1      <= 1'b0;
      sym_data_p1 <= '0;
      err_q       <= 1'b0;
    end else begin
      state  <= state_nxt;
      rd_ptr <= rd_ptr + consumed[5:0];
      fill   <= fill_nxt;
      if (sym_done) begin
        q_acc  <= 8'd0;
        k_lat  <= bus.k;
        vld_p1 <= 1'b0;
      end else begin
        q_acc <= q_acc_nxt;
      end
      // remainder stage -> registered symbol output
      if (load_sym) begin
        vld_p1      <= 1'b1;
        sym_data_p1 <= pack_sym(q_acc, k_lat, rem_p0);
      end
      if (set_err) err_q <= 1'b1;
    end
  end

  // Bit buffer storage: merge an accepted word into its 32-bit half.
  always_ff @(posedge clk) begin
    if (accept) bit_buf <= (bit_buf & ~wr_mask) | (wr_bits & wr_mask);
  end

endmodule

// File: tb/tb_rice_symbol_decoder.sv
// Self-checking bench for rice_symbol_decoder: table-driven streams with a
// scoreboard queue of expected symbols, plus hand-written backpressure,
// overflow and mid-operation reset sequences.
module tb_rice_symbol_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;

  rice_symbol_decoder_if #(.OUT_W(24)) bus ();

  rice_symbol_decoder #(.OUT_W(24), .Q_MAX(48)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]       k;
    logic [2:0]       nw;
    logic [3:0][31:0] w;
    logic [2:0]       ne;
    logic [3:0][31:0] e;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard: every handshake on the symbol port pops one expected value.
  always @(negedge clk) begin
    if (!rst && bus.sym_valid && bus.sym_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL extra_symbol: got %0d, expected no symbol", bus.sym_data);
      end else begin
        check("sym_data", 32'(bus.sym_data), exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_sym_valid", 32'(bus.sym_valid), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_sym_data", 32'(bus.sym_data), 32'd0);
  endtask

  task automatic send_word(input logic [31:0] w);
    int n;
    n            = 0;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.k         = 4'd0;
    bus.in_data   = 32'd0;
    bus.in_valid  = 1'b0;
    bus.sym_ready = 1'b1;

    for (int i = 0; i < 6; i++) vecs[i] = '0;
    // k=2: q=3,r=2 then q=0,r=3; trailing zeros accumulate silently
    vecs[0].k = 4'd2; vecs[0].nw = 3'd1; vecs[0].w[0] = 32'h1B80_0000;
    vecs[0].ne = 3'd2; vecs[0].e[0] = 32'd14; vecs[0].e[1] = 32'd3;
    // k=0: quotient spans two words, then a third word across the wrap
    vecs[1].k = 4'd0; vecs[1].nw = 3'd3;
    vecs[1].w[0] = 32'h0000_0000; vecs[1].w[1] = 32'h8000_0000; vecs[1].w[2] = 32'hA000_0000;
    vecs[1].ne = 3'd3; vecs[1].e[0] = 32'd32; vecs[1].e[1] = 32'd31; vecs[1].e[2] = 32'd1;
    // k=4: terminator at the last bit of word 0, remainder in word 1
    vecs[2].k = 4'd4; vecs[2].nw = 3'd2; vecs[2].w[0] = 32'h0000_0001; vecs[2].w[1] = 32'hF000_0000;
    vecs[2].ne = 3'd1; vecs[2].e[0] = 32'd511;
    // k=15: widest remainder
    vecs[3].k = 4'd15; vecs[3].nw = 3'd1; vecs[3].w[0] = 32'hFFFF_0000;
    vecs[3].ne = 3'd1; vecs[3].e[0] = 32'd32767;
    // k=0: quotient exactly at the legal maximum of 48
    vecs[4].k = 4'd0; vecs[4].nw = 3'd2; vecs[4].w[0] = 32'h0000_0000; vecs[4].w[1] = 32'h0000_8000;
    vecs[4].ne = 3'd1; vecs[4].e[0] = 32'd48;
    // k=1: back-to-back short symbols 0,1,2,3
    vecs[5].k = 4'd1; vecs[5].nw = 3'd1; vecs[5].w[0] = 32'hB4C0_0000;
    vecs[5].ne = 3'd4; vecs[5].e[0] = 32'd0; vecs[5].e[1] = 32'd1; vecs[5].e[2] = 32'd2; vecs[5].e[3] = 32'd3;

    for (int i = 0; i < 6; i++) begin
      bus.k = vecs[i].k;
      do_reset();
      for (int j = 0; j < int'(vecs[i].ne); j++) exp_q.push_back(vecs[i].e[j]);
      for (int j = 0; j < int'(vecs[i].nw); j++) send_word(vecs[i].w[j]);
      wait_drain("vec_drain");
      idle(60);
      check("vec_no_err", 32'(bus.err), 32'd0);
      check("vec_in_ready", 32'(bus.in_ready), 32'd1);
    end

    // Backpressure: symbol 0 held while a second word fills the buffer past 32 bits
    bus.k = 4'd0;
    do_reset();
    bus.sym_ready = 1'b0;
    send_word(32'h8000_0000);
    send_word(32'h4000_0000);
    begin
      int n;
      n = 0;
      while (!bus.sym_valid && n < 50) begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    check("bp_valid", 32'(bus.sym_valid), 32'd1);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", 32'(bus.sym_valid), 32'd1);
      check("bp_hold_data", 32'(bus.sym_data), 32'd0);
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    end
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd32);
    bus.sym_ready = 1'b1;
    wait_drain("bp_drain");
    idle(60);
    check("bp_in_ready_back", 32'(bus.in_ready), 32'd1);

    // Quotient overflow: 64 zeros exceed the limit and lock the decoder
    bus.k = 4'd0;
    do_reset();
    send_word(32'h0000_0000);
    send_word(32'h0000_0000);
    idle(3);
    check("ovf_err", 32'(bus.err), 32'd1);
    check("ovf_in_ready", 32'(bus.in_ready), 32'd0);
    check("ovf_sym_valid", 32'(bus.sym_valid), 32'd0);
    idle(10);
    check("ovf_err_held", 32'(bus.err), 32'd1);
    check("ovf_in_ready_held", 32'(bus.in_ready), 32'd0);
    do_reset();

    // Reset while in the remainder state with 20 bits buffered
    bus.k = 4'd3;
    do_reset();
    send_word(32'h0010_0000);
    @(posedge clk);
    #1;
    rst   = 1'b1;
    bus.k = 4'd1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("mid_rst_sym_valid", 32'(bus.sym_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.push_back(32'd1);
    send_word(32'hC000_0000);
    wait_drain("mid_rst_drain");
    idle(60);
    check("mid_rst_no_err", 32'(bus.err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
